imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time controller that owns the instruction memory programming port and the core run enable.
- Receives a framed byte stream from a serial front end over a valid/ready handshake.
- Assembles the bytes into little-endian 32-bit words and writes them sequentially through prog_en/prog_addr/prog_data.
- Releases the fetch stage (core_run, wired to the core's start) only after a complete, well-formed image has been written.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be 4-byte aligned.
- MAX_WORDS, 1024, largest accepted image length in words.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 0, maximum idle cycles between accepted bytes inside a frame; 0 disables the timeout.

Ports:
- clk  input  1  core clock
- start  input  1  synchronous active-low reset (low = reset)
- rx_valid  input  1  byte available
- rx_data  input  8  byte value
- rx_ready  output  1  byte accepted when rx_valid && rx_ready
- prog_en  output  1  imem write strobe, one cycle per word
- prog_addr  output  32  imem byte address
- prog_data  output  32  imem write word
- core_run  output  1  drives core start; high = core executing
- busy  output  1  frame in progress (LEN, DATA, CSUM)
- error  output  1  last frame rejected
- word_cnt  output  16  words written in current/last frame

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (start low on a rising edge of clk resets the block).
- Reset values:
  - state = IDLE.
  - prog_en = 0, prog_addr = BASE_ADDR, prog_data = 0.
  - core_run = 0, busy = 0, error = 0, word_cnt = 0.
  - All counters and the byte shift register = 0.
- Reset mid-frame aborts the frame. Words already written stay in imem.
- rx_ready is 1 in every state except for the single cycle in which prog_en is asserted.
  - This holds off a byte that would collide with the write.
  - All byte events below mean an accepted byte.
- States and transitions:
  - IDLE: SYNC_BYTE goes to LEN. Other bytes are discarded.
  - LEN: collect 4 bytes as length N, little-endian (first byte = N[7:0]).
    - On the 4th byte: if N > MAX_WORDS, go to ERR.
    - Else if N == 0, go to the post-data state (CSUM or RUN).
    - Else go to DATA. Clear error and word_cnt on entry.
  - DATA: shift bytes into a 32-bit word, first byte = bits [7:0].
    - The cycle after the 4th byte: prog_en = 1, prog_data = assembled word, prog_addr = BASE_ADDR + 4*word_cnt.
    - word_cnt increments in the same cycle.
    - After word N-1 is written, go to the post-data state.
  - RUN: core_run = 1 (registered, high from the first cycle in RUN).
    - SYNC_BYTE drops core_run next cycle and goes to LEN (reload). Other bytes are ignored.
  - ERR: error = 1, core_run = 0. SYNC_BYTE goes to LEN. Other bytes are discarded.
- Timeout (TIMEOUT_CYCLES > 0):
  - A gap counter runs in LEN, DATA and CSUM and clears on each accepted byte.
  - Reaching TIMEOUT_CYCLES goes to ERR.
  - A byte accepted in the same cycle as the limit wins (counter clears, no error).
- prog_addr arithmetic is 32-bit, with no wrap check beyond MAX_WORDS.
- prog_addr and prog_data hold their last value when prog_en = 0.
- busy = 1 exactly in LEN, DATA and CSUM.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined: after DATA (or after LEN when N == 0), state CSUM accepts one byte.
  - The byte is compared with the 8-bit modulo-256 sum of all data bytes (sum cleared on LEN entry).
  - Match goes to RUN. Mismatch goes to ERR.
- Undefined: no CSUM state and no sum register. The post-data state is RUN.

Decomposition:
- Shared riscv_defines package gets:
  - loader_state_t enum (IDLE, LEN, DATA, CSUM, RUN, ERR).
  - LOADER_SYNC_DEFAULT constant.
- One natural sub-module, byte_word_packer: 4-byte little-endian shift register with byte index and word_valid pulse; reused by LEN and DATA.

Test Plan:
- Nominal load, no checksum:
  - Stimulus: A5, 02 00 00 00, 13 00 00 00, 6F 00 00 00.
  - Required: prog_en pulses twice, (addr 0x0, data 0x00000013) then (addr 0x4, data 0x0000006F); core_run rises the cycle after the last write; word_cnt = 2.
- Oversize length:
  - Stimulus: A5, 01 04 00 00 (N = 1025).
  - Required: ERR, error = 1, no prog_en, core_run stays 0; a new frame A5, 00 00 00 00 reaches RUN and clears error.
- Reload from RUN:
  - Stimulus: after a completed load, send A5.
  - Required: core_run drops the next cycle, busy = 1, second image writes restart at BASE_ADDR.
- Timeout:
  - Setup: TIMEOUT_CYCLES = 8.
  - Stimulus: A5, 01 00 00 00, 13 00, then idle 8 cycles.
  - Required: ERR, no prog_en.
  - Separate case: a byte arriving on cycle 8 keeps the frame alive.
- Checksum, with IMEM_LOADER_CHECKSUM_EN:
  - Stimulus: A5, 01 00 00 00, 13 00 00 00, then checksum 13.
  - Required: RUN.
  - Same frame with checksum 14: ERR; the word is still written once.
- Reset and handshake:
  - Stimulus: drive start low for 1 cycle mid-DATA.
  - Required: all outputs at reset values the next cycle.
  - Handshake check: rx_valid held high continuously; rx_ready = 0 exactly on each prog_en cycle, and no byte is lost.

Source files
------------

// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared core definitions: instruction-memory loader state and sync marker
package riscv_defines;

   // Loader frame states; CSUM is only reachable with IMEM_LOADER_CHECKSUM_EN.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LEN  = 3'd1,
      DATA = 3'd2,
      CSUM = 3'd3,
      RUN  = 3'd4,
      ERR  = 3'd5
   } loader_state_t;

   localparam logic [7:0] LOADER_SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - 4-byte little-endian shift register with byte index and word pulse
//
// Ports:
//   clk_i         core clock
//   resetn_i      synchronous active-low reset
//   clear_i       restart assembly at byte 0
//   byte_valid_i  byte_data_i is shifted in this cycle
//   byte_data_i   byte value
//   word_o        assembled word including the byte presented this cycle
//   word_valid_o  high in the cycle the 4th byte of a word is presented
module byte_word_packer (
   input  logic        clk_i,
   input  logic        resetn_i,
   input  logic        clear_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic [31:0] word_o,
   output logic        word_valid_o
);

   logic [31:0] sr_q;
   logic [1:0]  idx_q;

   // Bytes enter at the top and move down, so the first byte ends in [7:0].
   assign word_o       = {byte_data_i, sr_q[31:8]};
   assign word_valid_o = byte_valid_i && (idx_q == 2'd3);

   always_ff @(posedge clk_i) begin
      if (!resetn_i || clear_i) begin
         sr_q  <= '0;
         idx_q <= '0;
      end else if (byte_valid_i) begin
         sr_q  <= word_o;
         idx_q <= idx_q + 2'd1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader writing a framed byte stream into imem, then releasing the core
//
// Optional checksum byte after the data: define IMEM_LOADER_CHECKSUM_EN.
//
// Ports:
//   clk        core clock
//   start      synchronous active-low reset
//   rx_valid   byte available         rx_data   byte value
//   rx_ready   byte accepted when rx_valid && rx_ready
//   prog_en    imem write strobe      prog_addr imem byte address   prog_data imem word
//   core_run   core start (high = executing)
//   busy       frame in progress      error     last frame rejected
//   word_cnt   words written in current/last frame
module imem_loader import riscv_defines::*; #(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned MAX_WORDS      = 1024,
   parameter logic [7:0]  SYNC_BYTE      = LOADER_SYNC_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        prog_en,
   output logic [31:0] prog_addr,
   output logic [31:0] prog_data,
   output logic        core_run,
   output logic        busy,
   output logic        error,
   output logic [15:0] word_cnt
);

   loader_state_t state_q, state_d, post_state;
   logic          prog_en_q;
   logic [31:0]   prog_addr_q, prog_data_q, gap_q;
   logic [15:0]   word_cnt_q, len_q;
   logic          accept, in_frame, frame_start, pack_valid, timeout_hit, write_now;
   logic [31:0]   pk_word;
   logic          pk_word_valid;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] sum_q;
   assign post_state = CSUM;
`else
   assign post_state = RUN;
`endif

   // The write cycle blocks intake so a byte can never race the strobe.
   assign rx_ready    = !prog_en_q;
   assign accept      = rx_valid && rx_ready;
   assign in_frame    = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
   assign frame_start = accept && (rx_data == SYNC_BYTE) &&
                        ((state_q == IDLE) || (state_q == RUN) || (state_q == ERR));
   assign pack_valid  = accept && ((state_q == LEN) || (state_q == DATA));
   assign write_now   = (state_q == DATA) && pk_word_valid;
   // A byte landing on the limit cycle wins over the timeout.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_frame && !accept &&
                        (gap_q == TIMEOUT_CYCLES - 1);

   byte_word_packer u_packer (
      .clk_i        (clk),
      .resetn_i     (start),
      .clear_i      (frame_start),
      .byte_valid_i (pack_valid),
      .byte_data_i  (rx_data),
      .word_o       (pk_word),
      .word_valid_o (pk_word_valid)
   );

   always_ff @(posedge clk) begin
      if (!start) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, RUN, ERR: if (frame_start) state_d = LEN;
         LEN: begin
            if (pk_word_valid) begin
               if (pk_word > MAX_WORDS) state_d = ERR;
               else if (pk_word == '0)  state_d = post_state;
               else                     state_d = DATA;
            end
         end
         // Leave only once the final word's strobe cycle has gone by.
         DATA: if (prog_en_q && (word_cnt_q == len_q)) state_d = post_state;
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM: if (accept) state_d = (rx_data == sum_q) ? RUN : ERR;
`else
         CSUM: state_d = ERR;
`endif
         default: state_d = IDLE;
      endcase
      if (timeout_hit) state_d = ERR;
   end

   always_comb begin
      busy     = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
      error    = (state_q == ERR);
      core_run = (state_q == RUN);
   end

   always_ff @(posedge clk) begin
      if (!start) begin
         prog_en_q   <= 1'b0;
         prog_addr_q <= BASE_ADDR;
         prog_data_q <= '0;
         word_cnt_q  <= '0;
         len_q       <= '0;
         gap_q       <= '0;
      end else begin
         prog_en_q <= write_now;
         if (write_now) begin
            prog_data_q <= pk_word;
            prog_addr_q <= BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
            word_cnt_q  <= word_cnt_q + 16'd1;
         end else if (frame_start) begin
            word_cnt_q  <= '0;
         end
         if ((state_q == LEN) && pk_word_valid) len_q <= pk_word[15:0];
         if (!in_frame || accept) gap_q <= '0;
         else                     gap_q <= gap_q + 32'd1;
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (!start)                              sum_q <= '0;
      else if (frame_start)                    sum_q <= '0;
      else if ((state_q == DATA) && accept)    sum_q <= sum_q + rx_data;
   end
`endif

   assign prog_en   = prog_en_q;
   assign prog_addr = prog_addr_q;
   assign prog_data = prog_data_q;
   assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader (timeout 8, optional checksum build)
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        start, rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready, prog_en, core_run, busy, error;
   logic [31:0] prog_addr, prog_data;
   logic [15:0] word_cnt;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t        exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         wr_idx;
   logic [7:0] sum_acc;

   always #5 clk = ~clk;

   imem_loader #(
      .BASE_ADDR      (32'h0000_0000),
      .MAX_WORDS      (1024),
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk       (clk),
      .start     (start),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .prog_en   (prog_en),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .core_run  (core_run),
      .busy      (busy),
      .error     (error),
      .word_cnt  (word_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Write monitor: every strobe must match the next scoreboard entry.
   wr_t mon_e;
   always @(negedge clk) begin
      if (prog_en) begin
         check("rx_ready_on_write", rx_ready, 0);
         if (exp_q.size() == 0) begin
            check("unexpected_prog_en", prog_en, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("prog_addr", prog_addr, mon_e.addr);
            check("prog_data", prog_data, mon_e.data);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int   n;
      logic ok;
      rx_valid = 1'b1;
      rx_data  = b;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 20) begin
         ok = rx_ready;
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      if (!ok) check("byte_accept_bound", rx_ready, 1);
   endtask

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_word32(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic data_word(input logic [31:0] w);
      exp_q.push_back('{32'(wr_idx * 4), w});
      wr_idx++;
      for (int i = 0; i < 4; i++) begin
         sum_acc = sum_acc + w[8*i +: 8];
         send_byte(w[8*i +: 8]);
      end
   endtask

   task automatic begin_frame(input logic [31:0] n);
      wr_idx  = 0;
      sum_acc = 8'h00;
      send_byte(8'hA5);
      check("sync_busy", busy, 1);
      check("sync_core_run", core_run, 0);
      check("sync_error", error, 0);
      send_word32(n);
   endtask

   task automatic finish_frame(input bit had_data, input string tag);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(sum_acc);
`else
      if (had_data) begin
         check({tag, "_run_during_write"}, core_run, 0);
         idle(1);
      end
`endif
      check({tag, "_core_run"}, core_run, 1);
      check({tag, "_error"}, error, 0);
      check({tag, "_busy"}, busy, 0);
      idle(1);
      check({tag, "_writes_done"}, exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time bound");
      $fatal(1, "watchdog");
   end

   initial begin
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_prog_en", prog_en, 0);
      check("rst_prog_addr", prog_addr, 32'h0);
      check("rst_core_run", core_run, 0);
      check("rst_busy", busy, 0);
      check("rst_word_cnt", word_cnt, 0);
      check("rst_rx_ready", rx_ready, 1);
      start = 1'b1;
      @(negedge clk);

      // Nominal two-word image, rx_valid held high throughout.
      begin_frame(2);
      data_word(32'h0000_0013);
      data_word(32'h0000_006F);
      finish_frame(1, "nominal");
      check("nominal_word_cnt", word_cnt, 2);

      // Non-sync byte in RUN is ignored.
      send_byte(8'h13);
      idle(1);
      check("run_ignore_core_run", core_run, 1);

      // Reload from RUN restarts at BASE_ADDR.
      begin_frame(1);
      data_word(32'hDEAD_BEEF);
      finish_frame(1, "reload");
      check("reload_word_cnt", word_cnt, 1);

      // Oversize length.
      begin_frame(32'd1025);
      check("oversize_error", error, 1);
      check("oversize_busy", busy, 0);
      check("oversize_core_run", core_run, 0);
      idle(3);
      check("oversize_error_hold", error, 1);
      begin_frame(0);
      finish_frame(0, "empty");
      check("empty_word_cnt", word_cnt, 0);

      // Timeout after 8 idle cycles.
      begin_frame(1);
      send_byte(8'h13);
      send_byte(8'h00);
      idle(7);
      check("tmo7_error", error, 0);
      check("tmo7_busy", busy, 1);
      idle(1);
      check("tmo8_error", error, 1);
      check("tmo8_busy", busy, 0);

      // Byte on the limit cycle keeps the frame alive.
      begin_frame(1);
      exp_q.push_back('{32'h0, 32'h0000_0013});
      sum_acc = 8'h13;
      send_byte(8'h13);
      send_byte(8'h00);
      idle(7);
      send_byte(8'h00);
      send_byte(8'h00);
      finish_frame(1, "tmo_save");

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Bad checksum: word written once, frame rejected.
      begin_frame(1);
      data_word(32'h0000_0013);
      send_byte(sum_acc + 8'h01);
      check("csum_bad_error", error, 1);
      check("csum_bad_core_run", core_run, 0);
      idle(1);
      check("csum_bad_writes", exp_q.size(), 0);
`endif

      // Reset mid-DATA.
      begin_frame(3);
      data_word(32'h1122_3344);
      data_word(32'h5566_7788);
      send_byte(8'h99);
      rx_valid = 1'b0;
      start    = 1'b0;
      @(negedge clk);
      start = 1'b1;
      check("mid_rst_prog_en", prog_en, 0);
      check("mid_rst_prog_addr", prog_addr, 32'h0);
      check("mid_rst_prog_data", prog_data, 32'h0);
      check("mid_rst_word_cnt", word_cnt, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_error", error, 0);
      check("mid_rst_core_run", core_run, 0);
      check("mid_rst_rx_ready", rx_ready, 1);

      begin_frame(1);
      data_word(32'hCAFE_F00D);
      finish_frame(1, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
